// File: rtl/ring_ctr_pkg.sv
// Shared mode/direction encodings for the multi-mode ring counter.
package ring_ctr_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check and step-index decode for a ring/Johnson state.
// Ring: legal when exactly one bit is set; pos is that bit's index.
// Johnson: legal for LSB- or MSB-anchored thermometer codes.
// Johnson pos is 0 for all-zeros, popcount when q[0] is set, else 2*WIDTH-popcount.
// An illegal state always decodes to pos 0.
module ring_state_check
  import ring_ctr_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int POS_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal,
  output logic [POS_W-1:0] pos
);

  int               ones;
  int               idx;
  int               val;
  logic [WIDTH-1:0] inv;
  logic             lsb_therm;
  logic             msb_therm;

  // Count set bits, find the set-bit index, classify the code and decode pos.
  always_comb begin
    ones      = 0;
    idx       = 0;
    val       = 0;
    inv       = ~q;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        ones = ones + 1;
        idx  = i;
      end
    end
    // 0..01..1 has no bit set in common with itself plus one; 1..10..0 is its complement.
    lsb_therm = ((q & (q + WIDTH'(1))) == '0);
    msb_therm = ((inv & (inv + WIDTH'(1))) == '0);
    if (mode == MODE_RING) begin
      legal = (ones == 1);
      val   = idx;
    end else begin
      legal = lsb_therm || msb_therm;
      if (q == '0) begin
        val = 0;
      end else if (q[0]) begin
        val = ones;
      end else begin
        val = 2 * WIDTH - ones;
      end
    end
    pos = legal ? POS_W'(val) : '0;
  end

endmodule

// File: rtl/multi_mode_ring_counter.sv
// Ring / Johnson counter with selectable direction, checked synchronous load,
// automatic recovery from illegal states, and registered wrap/err pulses.
// WIDTH must be at least 2.
module multi_mode_ring_counter
  import ring_ctr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          mode,
  input  logic                          dir,
  input  logic                          load,
  input  logic [WIDTH-1:0]              load_val,
  output logic [WIDTH-1:0]              q,
  output logic [$clog2(2*WIDTH)-1:0]    pos,
  output logic                          wrap,
  output logic                          err
);

  localparam int               POS_W   = $clog2(2 * WIDTH);
  localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);

  logic             q_legal;
  logic             load_legal;
  logic [POS_W-1:0] load_pos_unused;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] start;

  ring_state_check #(.WIDTH(WIDTH)) u_q_check (
    .q     (q),
    .mode  (mode),
    .legal (q_legal),
    .pos   (pos)
  );

  ring_state_check #(.WIDTH(WIDTH)) u_load_check (
    .q     (load_val),
    .mode  (mode),
    .legal (load_legal),
    .pos   (load_pos_unused)
  );

  // Next state for one advance step, and the sequence start state for the current mode.
  always_comb begin
    adv   = q;
    start = (mode == MODE_RING) ? Q_ONE : '0;
    case ({mode, dir})
      {MODE_RING,    DIR_LEFT}  : adv = {q[WIDTH-2:0], q[WIDTH-1]};
      {MODE_RING,    DIR_RIGHT} : adv = {q[0], q[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_LEFT}  : adv = {q[WIDTH-2:0], ~q[WIDTH-1]};
      default                   : adv = {~q[0], q[WIDTH-1:1]};
    endcase
  end

  // State register with load > en > hold priority; wrap/err are one-cycle pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q    <= Q_ONE;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (load) begin
        if (load_legal) begin
          q <= load_val;
        end else begin
          err <= 1'b1;
        end
      end else if (en) begin
        if (!q_legal) begin
          q   <= Q_ONE;
          err <= 1'b1;
        end else begin
          q    <= adv;
          wrap <= (adv == start);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_mode_ring_counter.sv
// Directed testbench for multi_mode_ring_counter (WIDTH = 4).
module tb_multi_mode_ring_counter;

  logic       clock;
  logic       reset;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] pos;
  logic       wrap;
  logic       err;

  int total = 0;
  int bad   = 0;

  multi_mode_ring_counter #(.WIDTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .pos      (pos),
    .wrap     (wrap),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check q, pos, wrap and err together.
  task automatic chk_all(input string tag, input logic [3:0] eq, input logic [2:0] ep,
                         input logic ew, input logic ee);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".pos"},  32'(pos),  32'(ep));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    chk({tag, ".err"},  32'(err),  32'(ee));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] jl_q   [8];
  logic [2:0] jl_pos [8];

  initial begin
    jl_q   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    jl_pos = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;
    #1;
    chk_all("reset_async", 4'b0001, 3'd0, 1'b0, 1'b0);
    step();
    // Reset overrides a pending load.
    load = 1'b1; load_val = 4'b1000;
    step();
    chk_all("reset_over_load", 4'b0001, 3'd0, 1'b0, 1'b0);
    load = 1'b0;
    reset = 1'b0;

    // Ring-left from 0001.
    en = 1'b1;
    step(); chk_all("rl1", 4'b0010, 3'd1, 1'b0, 1'b0);
    step(); chk_all("rl2", 4'b0100, 3'd2, 1'b0, 1'b0);
    step(); chk_all("rl3", 4'b1000, 3'd3, 1'b0, 1'b0);
    step(); chk_all("rl4", 4'b0001, 3'd0, 1'b1, 1'b0);
    en = 1'b0;
    step(); chk_all("hold_after_wrap", 4'b0001, 3'd0, 1'b0, 1'b0);

    // Johnson-left full sequence from 0000.
    mode = 1'b1; load = 1'b1; load_val = 4'b0000;
    step(); chk_all("jl_load", 4'b0000, 3'd0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("jl%0d", i + 1), jl_q[i], jl_pos[i], (i == 7), 1'b0);
    end

    // Johnson-right, first two steps from 0000.
    dir = 1'b1;
    step(); chk_all("jr1", 4'b1000, 3'd7, 1'b0, 1'b0);
    step(); chk_all("jr2", 4'b1100, 3'd6, 1'b0, 1'b0);

    // Ring-right from 0001; load takes priority over en.
    mode = 1'b0; load = 1'b1; load_val = 4'b0001;
    step(); chk_all("rr_load", 4'b0001, 3'd0, 1'b0, 1'b0);
    load = 1'b0;
    step(); chk_all("rr1", 4'b1000, 3'd3, 1'b0, 1'b0);
    step(); chk_all("rr2", 4'b0100, 3'd2, 1'b0, 1'b0);
    step(); chk_all("rr3", 4'b0010, 3'd1, 1'b0, 1'b0);
    step(); chk_all("rr4", 4'b0001, 3'd0, 1'b1, 1'b0);

    // Ring at 0100, switch to Johnson: illegal state is corrected to 0001.
    en = 1'b0; dir = 1'b0; load = 1'b1; load_val = 4'b0100;
    step(); chk_all("ring_0100", 4'b0100, 3'd2, 1'b0, 1'b0);
    load = 1'b0; mode = 1'b1;
    #1;
    chk("illegal_pos", 32'(pos), 32'd0);
    en = 1'b1;
    step(); chk_all("correct", 4'b0001, 3'd1, 1'b0, 1'b1);
    en = 1'b0;
    step(); chk_all("correct_clr", 4'b0001, 3'd1, 1'b0, 1'b0);

    // Illegal load in ring mode: q held, err pulse.
    mode = 1'b0; load = 1'b1; load_val = 4'b0101;
    step(); chk_all("bad_load", 4'b0001, 3'd0, 1'b0, 1'b1);
    load = 1'b0;
    step(); chk_all("bad_load_clr", 4'b0001, 3'd0, 1'b0, 1'b0);

    // Mid-sequence asynchronous reset between edges.
    en = 1'b1;
    step(); chk("pre_rst1.q", 32'(q), 32'(4'b0010));
    step(); chk("pre_rst2.q", 32'(q), 32'(4'b0100));
    #2 reset = 1'b1;
    #1;
    chk_all("mid_reset", 4'b0001, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 4'b0001, 3'd0, 1'b0, 1'b0);
    end
    en = 1'b1;
    step(); chk_all("after_reset_adv", 4'b0010, 3'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
